// File: rtl/pixel_pair_packer.sv
// pixel_pair_packer: packs horizontally adjacent 32-bit pixels (colour and Z)
// into 64-bit frame-buffer word writes and drives the write-FIFO enqueue port.
// A single hold register collects up to two lanes of one word. The word is
// emitted when a pixel for a different word arrives, on a flush request, or
// after a run of idle cycles. Output fields are registered and change only on
// the cycle that the enqueue strobe is raised.
// Handshake: a pixel transfers on a cycle where pixel_valid && pixel_ready.
// pixel_ready is combinational and depends only on fifo_size and flush_pending.
module pixel_pair_packer #(
    parameter int SCREEN_WIDTH    = 800,
    parameter int FIFO_DEPTH      = 32,
    parameter int FIFO_DEPTH_LOG2 = 5,
    parameter int SLACK           = 4,
    parameter int IDLE_FLUSH      = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [28:0]                color_base,
    input  logic [28:0]                z_base,
    input  logic                       z_enable,
    input  logic                       pixel_valid,
    output logic                       pixel_ready,
    input  logic [9:0]                 pixel_x,
    input  logic [9:0]                 pixel_y,
    input  logic [31:0]                pixel_color,
    input  logic [31:0]                pixel_z,
    input  logic                       flush,
    input  logic [FIFO_DEPTH_LOG2-1:0] fifo_size,
    output logic                       enqueue,
    output logic [28:0]                color_address,
    output logic [63:0]                color,
    output logic [28:0]                z_address,
    output logic [63:0]                z,
    output logic [1:0]                 pixel_active,
    output logic                       idle
);

    localparam int WORDS_PER_LINE = SCREEN_WIDTH / 2;
    localparam int CNT_W          = $clog2(IDLE_FLUSH + 1);
    localparam logic [FIFO_DEPTH_LOG2:0] ACCEPT_LIMIT = (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH - SLACK);
    localparam logic [FIFO_DEPTH_LOG2:0] EMIT_LIMIT   = (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]         CNT_MAX      = CNT_W'(IDLE_FLUSH);
    localparam logic [CNT_W-1:0]         CNT_TRIGGER  = CNT_W'(IDLE_FLUSH - 1);

    // Hold register and control state
    logic             held_valid_q, held_valid_d;
    logic [28:0]      hold_off_q, hold_off_d;
    logic [1:0]       active_q, active_d;
    logic [31:0]      c0_q, c0_d, c1_q, c1_d;
    logic [31:0]      z0_q, z0_d, z1_q, z1_d;
    logic             flush_pending_q, flush_pending_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    // Registered output fields
    logic             enqueue_q, enqueue_d;
    logic [28:0]      color_address_q, color_address_d;
    logic [28:0]      z_address_q, z_address_d;
    logic [63:0]      color_q, color_d, z_q, z_d;
    logic [1:0]       pixel_active_q, pixel_active_d;

    logic [28:0]      pix_off;
    logic             accept;
    logic             emit;
    logic             fifo_has_room;

    assign fifo_has_room = {1'b0, fifo_size} < EMIT_LIMIT;
    assign pixel_ready   = ({1'b0, fifo_size} < ACCEPT_LIMIT) && !flush_pending_q;
    assign accept        = pixel_valid && pixel_ready;
    assign pix_off       = 29'(29'(pixel_y) * 29'(WORDS_PER_LINE)) + 29'(pixel_x[9:1]);

    // Next-state: pixel merge/load, flush handling, idle counter, output capture
    always_comb begin
        held_valid_d    = held_valid_q;
        hold_off_d      = hold_off_q;
        active_d        = active_q;
        c0_d            = c0_q;
        c1_d            = c1_q;
        z0_d            = z0_q;
        z1_d            = z1_q;
        flush_pending_d = flush_pending_q;
        idle_cnt_d      = idle_cnt_q;
        enqueue_d       = 1'b0;
        color_address_d = color_address_q;
        z_address_d     = z_address_q;
        color_d         = color_q;
        z_d             = z_q;
        pixel_active_d  = pixel_active_q;
        emit            = 1'b0;

        if (accept) begin
            // A different word evicts the held one; room is guaranteed by pixel_ready.
            if (held_valid_q && (pix_off != hold_off_q)) begin
                emit = 1'b1;
            end
            if (!held_valid_q || (pix_off != hold_off_q)) begin
                hold_off_d = pix_off;
                active_d   = 2'b00;
                c0_d       = '0;
                c1_d       = '0;
                z0_d       = '0;
                z1_d       = '0;
            end
            if (pixel_x[0]) begin
                active_d[1] = 1'b1;
                c1_d        = pixel_color;
                z1_d        = pixel_z;
            end else begin
                active_d[0] = 1'b1;
                c0_d        = pixel_color;
                z0_d        = pixel_z;
            end
            held_valid_d = 1'b1;
            idle_cnt_d   = '0;
        end else if (flush_pending_q) begin
            if (held_valid_q) begin
                if (fifo_has_room) begin
                    emit            = 1'b1;
                    held_valid_d    = 1'b0;
                    active_d        = 2'b00;
                    flush_pending_d = 1'b0;
                    idle_cnt_d      = '0;
                end
            end else begin
                flush_pending_d = 1'b0;
            end
        end else if (held_valid_q) begin
            if (idle_cnt_q != CNT_MAX) begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
            if (idle_cnt_q == CNT_TRIGGER) begin
                flush_pending_d = 1'b1;
            end
        end else begin
            idle_cnt_d = '0;
        end

        if (flush) begin
            flush_pending_d = 1'b1;
        end

        if (emit) begin
            enqueue_d       = 1'b1;
            color_address_d = color_base + hold_off_q;
            z_address_d     = z_enable ? (z_base + hold_off_q) : '0;
            color_d         = {active_q[1] ? c1_q : 32'd0, active_q[0] ? c0_q : 32'd0};
            z_d             = {active_q[1] ? z1_q : 32'd0, active_q[0] ? z0_q : 32'd0};
            pixel_active_d  = active_q;
        end
    end

    // State and output registers; reset discards any held word
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            held_valid_q    <= 1'b0;
            hold_off_q      <= '0;
            active_q        <= 2'b00;
            c0_q            <= '0;
            c1_q            <= '0;
            z0_q            <= '0;
            z1_q            <= '0;
            flush_pending_q <= 1'b0;
            idle_cnt_q      <= '0;
            enqueue_q       <= 1'b0;
            color_address_q <= '0;
            z_address_q     <= '0;
            color_q         <= '0;
            z_q             <= '0;
            pixel_active_q  <= 2'b00;
        end else begin
            held_valid_q    <= held_valid_d;
            hold_off_q      <= hold_off_d;
            active_q        <= active_d;
            c0_q            <= c0_d;
            c1_q            <= c1_d;
            z0_q            <= z0_d;
            z1_q            <= z1_d;
            flush_pending_q <= flush_pending_d;
            idle_cnt_q      <= idle_cnt_d;
            enqueue_q       <= enqueue_d;
            color_address_q <= color_address_d;
            z_address_q     <= z_address_d;
            color_q         <= color_d;
            z_q             <= z_d;
            pixel_active_q  <= pixel_active_d;
        end
    end

    assign enqueue       = enqueue_q;
    assign color_address = color_address_q;
    assign z_address     = z_address_q;
    assign color         = color_q;
    assign z             = z_q;
    assign pixel_active  = pixel_active_q;
    assign idle          = !held_valid_q && !flush_pending_q;

endmodule

// File: tb/tb_pixel_pair_packer.sv
// Directed bench for pixel_pair_packer: pixel pairing, word eviction, flush,
// auto-flush, backpressure and reset discard, against hand-computed words.
module tb_pixel_pair_packer;

    logic        clock;
    logic        reset_n;
    logic [28:0] color_base;
    logic [28:0] z_base;
    logic        z_enable;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [31:0] pixel_color;
    logic [31:0] pixel_z;
    logic        flush;
    logic [4:0]  fifo_size;
    logic        enqueue;
    logic [28:0] color_address;
    logic [63:0] color;
    logic [28:0] z_address;
    logic [63:0] z;
    logic [1:0]  pixel_active;
    logic        idle;

    int n_checks = 0;
    int n_errors = 0;
    int enq_count = 0;
    int base_cnt;
    int lat;

    pixel_pair_packer dut (
        .clock(clock), .reset_n(reset_n), .color_base(color_base), .z_base(z_base),
        .z_enable(z_enable), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color), .pixel_z(pixel_z),
        .flush(flush), .fifo_size(fifo_size), .enqueue(enqueue),
        .color_address(color_address), .color(color), .z_address(z_address), .z(z),
        .pixel_active(pixel_active), .idle(idle)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // count enqueue strobes away from the active edge
    always @(negedge clock) begin
        if (enqueue === 1'b1) enq_count = enq_count + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic send(input int x, input int y, input logic [31:0] c, input logic [31:0] zz);
        @(negedge clock);
        pixel_valid = 1'b1;
        pixel_x     = 10'(x);
        pixel_y     = 10'(y);
        pixel_color = c;
        pixel_z     = zz;
        @(posedge clock);
        #1;
        pixel_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        #1;
    endtask

    initial begin
        reset_n = 1'b0; color_base = 29'd1000; z_base = 29'd5000; z_enable = 1'b1;
        pixel_valid = 1'b0; pixel_x = '0; pixel_y = '0; pixel_color = '0; pixel_z = '0;
        flush = 1'b0; fifo_size = '0;
        wait_cycles(3);
        check("rst_enqueue", {63'd0, enqueue}, 64'd0);
        check("rst_idle", {63'd0, idle}, 64'd1);
        check("rst_ready", {63'd0, pixel_ready}, 64'd1);
        check("rst_caddr", {35'd0, color_address}, 64'd0);
        check("rst_active", {62'd0, pixel_active}, 64'd0);
        reset_n = 1'b1;
        wait_cycles(2);

        // 1: full pair (4,0),(5,0) -> word 2
        base_cnt = enq_count;
        send(4, 0, 32'h11110004, 32'h22220004);
        send(5, 0, 32'h11110005, 32'h22220005);
        check("t1_held_noenq", 64'(enq_count - base_cnt), 64'd0);
        check("t1_busy", {63'd0, idle}, 64'd0);
        pulse_flush();
        wait_cycles(4);
        check("t1_count", 64'(enq_count - base_cnt), 64'd1);
        check("t1_caddr", {35'd0, color_address}, 64'd1002);
        check("t1_zaddr", {35'd0, z_address}, 64'd5002);
        check("t1_active", {62'd0, pixel_active}, 64'd3);
        check("t1_color", color, 64'h11110005_11110004);
        check("t1_z", z, 64'h22220005_22220004);
        check("t1_idle", {63'd0, idle}, 64'd1);

        // 2: single odd pixel (5,1) -> word 402
        base_cnt = enq_count;
        send(5, 1, 32'hAAAA0005, 32'hBBBB0005);
        pulse_flush();
        wait_cycles(4);
        check("t2_count", 64'(enq_count - base_cnt), 64'd1);
        check("t2_caddr", {35'd0, color_address}, 64'd1402);
        check("t2_active", {62'd0, pixel_active}, 64'd2);
        check("t2_color", color, 64'hAAAA0005_00000000);

        // 3: (2,0) then (6,0) evicts word 1, word 3 stays held
        base_cnt = enq_count;
        send(2, 0, 32'h33330002, 32'h44440002);
        send(6, 0, 32'h33330006, 32'h44440006);
        wait_cycles(2);
        check("t3_evict_count", 64'(enq_count - base_cnt), 64'd1);
        check("t3_caddr", {35'd0, color_address}, 64'd1001);
        check("t3_active", {62'd0, pixel_active}, 64'd1);
        check("t3_color", color, 64'h00000000_33330002);
        check("t3_held", {63'd0, idle}, 64'd0);
        pulse_flush();
        wait_cycles(4);
        check("t3_flush_count", 64'(enq_count - base_cnt), 64'd2);
        check("t3_caddr2", {35'd0, color_address}, 64'd1003);

        // 4: z suppressed, then backpressure threshold
        base_cnt = enq_count;
        z_enable = 1'b0;
        send(0, 2, 32'h55550000, 32'h66660000);
        pulse_flush();
        wait_cycles(4);
        check("t4_count", 64'(enq_count - base_cnt), 64'd1);
        check("t4_caddr", {35'd0, color_address}, 64'd1800);
        check("t4_zaddr", {35'd0, z_address}, 64'd0);
        z_enable = 1'b1;
        fifo_size = 5'd28;
        #1;
        check("t4_ready_28", {63'd0, pixel_ready}, 64'd0);
        fifo_size = 5'd27;
        #1;
        check("t4_ready_27", {63'd0, pixel_ready}, 64'd1);
        fifo_size = 5'd0;

        // flush held off while the FIFO is one short of full
        base_cnt = enq_count;
        send(0, 3, 32'h77770000, 32'h88880000);
        fifo_size = 5'd31;
        pulse_flush();
        wait_cycles(4);
        check("full_no_enq", 64'(enq_count - base_cnt), 64'd0);
        check("full_held", {63'd0, idle}, 64'd0);
        fifo_size = 5'd30;
        wait_cycles(4);
        check("full_release", 64'(enq_count - base_cnt), 64'd1);
        check("full_caddr", {35'd0, color_address}, 64'd2200);
        fifo_size = 5'd0;

        // 5: idle auto-flush
        base_cnt = enq_count;
        lat = 0;
        send(10, 0, 32'h99990010, 32'h12340010);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (enqueue === 1'b1 && lat == 0) lat = i;
        end
        #1;
        check("t5_latency_ok", {63'd0, (lat >= 17 && lat <= 18)}, 64'd1);
        check("t5_count", 64'(enq_count - base_cnt), 64'd1);
        check("t5_caddr", {35'd0, color_address}, 64'd1005);
        check("t5_idle", {63'd0, idle}, 64'd1);

        // 6: repeated lane, last write wins
        base_cnt = enq_count;
        send(3, 0, 32'hA0A0A0A0, 32'h0A0A0A0A);
        send(3, 0, 32'hB0B0B0B0, 32'h0B0B0B0B);
        pulse_flush();
        wait_cycles(4);
        check("t6_count", 64'(enq_count - base_cnt), 64'd1);
        check("t6_active", {62'd0, pixel_active}, 64'd2);
        check("t6_color", color, 64'hB0B0B0B0_00000000);
        check("t6_z", z, 64'h0B0B0B0B_00000000);

        // reset while a word is held discards it
        base_cnt = enq_count;
        send(8, 4, 32'hCAFE0008, 32'hBEEF0008);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst_mid_idle", {63'd0, idle}, 64'd1);
        check("rst_mid_caddr", {35'd0, color_address}, 64'd0);
        wait_cycles(2);
        reset_n = 1'b1;
        pulse_flush();
        wait_cycles(4);
        check("rst_mid_no_enq", 64'(enq_count - base_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
